// File: rtl/xio.sv
// xio: Atari 8-bit expansion-bus I/O block.
// Register page at REG_PAGE ($D700-$D706) plus a relocatable aperture that maps
// A8 addresses onto an internal RAM. The asynchronous A8 bus is sampled with the
// fast FPGA clock; phi2 is synchronised and edge-detected to run a per-cycle
// sequencer (IDLE -> DECODE -> ACTIVE -> IDLE).
// Build option: define XIO_IRQ_EN to include the $D706 pending flag and /IRQ.
module xio #(
    parameter int          WR_SAMPLE = 40,
    parameter int          RAM_AW    = 12,
    parameter logic [7:0]  REG_PAGE  = 8'hD7
) (
    input  logic        clk,
    input  logic        a8_rst_n,
    input  logic        a8_clk,
    input  logic        a8_halt_n,
    input  logic        a8_ref_n,
    input  logic        a8_rw,
    input  logic        a8_rd5,
    input  logic        a8_rd4,
    input  logic        a8_s5_n,
    input  logic        a8_s4_n,
    input  logic [15:0] a8_addr,
    inout  wire  [7:0]  a8_data,
    output logic        a8_data_oe,
    output logic        a8_irq_n,
    output logic        a8_mpd_n,
    output logic        a8_extsel_n
);

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_ACTIVE} state_t;
    typedef enum logic [1:0] {C_NONE, C_REG, C_APER} cls_t;

    state_t      state_q, state_d;
    cls_t        cls_q, cls_d;
    logic [2:0]  phi2_sync;
    logic        phi2_hi, phi2_rise;
    logic [15:0] addr_q;
    logic        rw_q;
    logic [7:0]  wr_cnt;
    logic [7:0]  ctrl_q, start_q, end_q;
    logic [23:0] base_q;
    logic [23:0] aper_sum;
    logic [RAM_AW-1:0] ram_idx;
    logic [7:0]  ram [0:(2**RAM_AW)-1];
    logic [7:0]  ram_q;
    logic [7:0]  rd_data;
    logic [7:0]  irq_rd;
    logic        cycle_start, wr_strobe, reg_wr, ram_wr;
    logic        in_reg_page, reg_hit, aper_hit;

    // Cartridge/halt lines are monitored only; upper sum bits fall outside the RAM.
    logic unused_sig;
    assign unused_sig = &{1'b0, a8_halt_n, a8_rd5, a8_rd4, a8_s5_n, a8_s4_n,
                          aper_sum[23:RAM_AW]};

    // Two-flop synchroniser for phi2 plus one extra stage for edge detection.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values of the others, exactly as the hardware does.
    always_ff @(posedge clk or negedge a8_rst_n) begin
        if (!a8_rst_n) phi2_sync <= '0;
        else           phi2_sync <= {phi2_sync[1:0], a8_clk};
    end

    assign phi2_hi   = phi2_sync[1];
    assign phi2_rise = phi2_sync[1] & ~phi2_sync[2];

    // Sequencer state register.
    always_ff @(posedge clk or negedge a8_rst_n) begin
        if (!a8_rst_n) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // Sequencer next state; refresh cycles never leave IDLE. ACTIVE exits on the
    // synced phi2 level so a fall can never be missed.
    // NOTE: the default assigned first keeps this block free of inferred latches.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (phi2_rise && a8_ref_n) state_d = S_DECODE;
            S_DECODE: state_d = S_ACTIVE;
            S_ACTIVE: if (!phi2_hi) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign cycle_start = (state_q == S_IDLE) && phi2_rise && a8_ref_n;

    // Latch address/direction at cycle start and count clocks since the synced rise.
    always_ff @(posedge clk or negedge a8_rst_n) begin
        if (!a8_rst_n) begin
            addr_q <= '0;
            rw_q   <= 1'b1;
            wr_cnt <= '0;
        end else if (cycle_start) begin
            addr_q <= a8_addr;
            rw_q   <= a8_rw;
            wr_cnt <= 8'd1;
        end else if (wr_cnt != '1) begin
            wr_cnt <= wr_cnt + 8'd1;
        end
    end

    // Classify the latched address; the register page always beats the aperture.
    always_comb begin
        in_reg_page = (addr_q[15:8] == REG_PAGE);
        reg_hit     = in_reg_page && (addr_q[7:0] <= 8'h06);
        aper_hit    = ctrl_q[0] && !in_reg_page &&
                      (addr_q[15:8] >= start_q) && (addr_q[15:8] <= end_q);
        cls_d       = C_NONE;
        if (reg_hit)       cls_d = C_REG;
        else if (aper_hit) cls_d = C_APER;
    end

    // Hold the classification for the rest of the cycle.
    always_ff @(posedge clk or negedge a8_rst_n) begin
        if (!a8_rst_n)                 cls_q <= C_NONE;
        else if (state_q == S_DECODE)  cls_q <= cls_d;
    end

    // Aperture index: BASE + addr - START page, wrapped to the RAM size.
    assign aper_sum = base_q + {8'h00, addr_q} - {8'h00, start_q, 8'h00};
    assign ram_idx  = aper_sum[RAM_AW-1:0];

    // Write data is taken WR_SAMPLE clocks after the rise, only while phi2 is high.
    assign wr_strobe = (state_q == S_ACTIVE) && !rw_q && phi2_hi &&
                       (wr_cnt == 8'(WR_SAMPLE));
    assign reg_wr    = wr_strobe && (cls_q == C_REG);
    assign ram_wr    = wr_strobe && (cls_q == C_APER);

    // Register file writes.
    always_ff @(posedge clk or negedge a8_rst_n) begin
        if (!a8_rst_n) begin
            ctrl_q  <= '0;
            base_q  <= '0;
            start_q <= '0;
            end_q   <= '0;
        end else if (reg_wr) begin
            case (addr_q[2:0])
                3'd0:    ctrl_q        <= a8_data;
                3'd1:    base_q[7:0]   <= a8_data;
                3'd2:    base_q[15:8]  <= a8_data;
                3'd3:    base_q[23:16] <= a8_data;
                3'd4:    start_q       <= a8_data;
                3'd5:    end_q         <= a8_data;
                default: ;
            endcase
        end
    end

`ifdef XIO_IRQ_EN
    logic irq_pend_q;

    // IRQ pending flag, set/cleared by software through $D706 bit 0.
    always_ff @(posedge clk or negedge a8_rst_n) begin
        if (!a8_rst_n)                           irq_pend_q <= 1'b0;
        else if (reg_wr && addr_q[2:0] == 3'd6)  irq_pend_q <= a8_data[0];
    end

    assign a8_irq_n = ~(ctrl_q[1] & irq_pend_q);
    assign irq_rd   = {7'b0, irq_pend_q};
`else
    assign a8_irq_n = 1'b1;
    assign irq_rd   = 8'h00;
`endif

    // Aperture RAM: read issued in DECODE, data used from ACTIVE onwards.
    // NOTE: the RAM array and its read register have no reset; clearing a memory
    // needs a sequencer, and its contents come from FPGA configuration.
    always_ff @(posedge clk) begin
        if (ram_wr)                ram[ram_idx] <= a8_data;
        if (state_q == S_DECODE)   ram_q        <= ram[ram_idx];
    end

    // Read-data mux for the register page and the aperture.
    always_comb begin
        rd_data = 8'h00;
        if (cls_q == C_APER) begin
            rd_data = ram_q;
        end else begin
            case (addr_q[2:0])
                3'd0:    rd_data = ctrl_q;
                3'd1:    rd_data = base_q[7:0];
                3'd2:    rd_data = base_q[15:8];
                3'd3:    rd_data = base_q[23:16];
                3'd4:    rd_data = start_q;
                3'd5:    rd_data = end_q;
                3'd6:    rd_data = irq_rd;
                default: rd_data = 8'h00;
            endcase
        end
    end

    assign a8_data_oe  = (state_q == S_ACTIVE) && rw_q && (cls_q != C_NONE);
    assign a8_data     = a8_data_oe ? rd_data : 8'hzz;
    assign a8_extsel_n = ~(((state_q == S_DECODE) && (cls_d == C_APER)) ||
                           ((state_q == S_ACTIVE) && (cls_q == C_APER)));
    assign a8_mpd_n    = ~((state_q == S_ACTIVE) && ctrl_q[2] &&
                           (addr_q[15:11] == 5'b11011));

endmodule

// File: tb/tb_xio.sv
// tb_xio: directed bench for xio. Drives A8 bus cycles (phi2 ~1.79 MHz) against
// a 200 MHz clk and checks register, aperture, /EXTSEL, /MPD, /IRQ and ref behaviour.
`timescale 1ns/100ps
module tb_xio;

    logic        clk = 1'b0;
    logic        a8_rst_n, a8_clk, a8_halt_n, a8_ref_n, a8_rw;
    logic        a8_rd5, a8_rd4, a8_s5_n, a8_s4_n;
    logic [15:0] a8_addr;
    wire  [7:0]  a8_data;
    logic        a8_data_oe, a8_irq_n, a8_mpd_n, a8_extsel_n;

    logic        drv_en;
    logic [7:0]  drv_data;
    assign a8_data = drv_en ? drv_data : 8'hzz;

    int n_checks = 0;
    int n_fail   = 0;

    // Values sampled mid-phi2 by the last bus cycle.
    logic       s_oe, s_ext, s_mpd;
    logic [7:0] s_data;

    xio dut (
        .clk(clk), .a8_rst_n(a8_rst_n), .a8_clk(a8_clk), .a8_halt_n(a8_halt_n),
        .a8_ref_n(a8_ref_n), .a8_rw(a8_rw), .a8_rd5(a8_rd5), .a8_rd4(a8_rd4),
        .a8_s5_n(a8_s5_n), .a8_s4_n(a8_s4_n), .a8_addr(a8_addr), .a8_data(a8_data),
        .a8_data_oe(a8_data_oe), .a8_irq_n(a8_irq_n), .a8_mpd_n(a8_mpd_n),
        .a8_extsel_n(a8_extsel_n)
    );

    always #2.5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One A8 cycle: setup, phi2 high for high_ns, sample at ~60 ns into phi2 high.
    task automatic bus_cycle(input logic [15:0] addr, input logic rw, input logic [7:0] wdata,
                             input logic ref_n, input int high_ns);
        a8_addr  = addr;
        a8_rw    = rw;
        a8_ref_n = ref_n;
        drv_en   = ~rw;
        drv_data = wdata;
        #100;
        a8_clk = 1'b1;
        #60;
        @(negedge clk);
        s_oe   = a8_data_oe;
        s_data = a8_data;
        s_ext  = a8_extsel_n;
        s_mpd  = a8_mpd_n;
        #(high_ns - 65);
        a8_clk = 1'b0;
        #150;
        drv_en   = 1'b0;
        a8_rw    = 1'b1;
        a8_ref_n = 1'b1;
        #28;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [7:0] d);
        bus_cycle(addr, 1'b0, d, 1'b1, 280);
    endtask

    task automatic rd(input logic [15:0] addr);
        bus_cycle(addr, 1'b1, 8'h00, 1'b1, 280);
    endtask

    initial begin
        a8_rst_n = 1'b0; a8_clk = 1'b0; a8_halt_n = 1'b1; a8_ref_n = 1'b1; a8_rw = 1'b1;
        a8_rd5 = 1'b0; a8_rd4 = 1'b0; a8_s5_n = 1'b1; a8_s4_n = 1'b1;
        a8_addr = 16'h0000; drv_en = 1'b0; drv_data = 8'h00;
        for (int i = 0; i < 4096; i++) dut.ram[i] = 8'h00;   // configuration contents

        #558;
        @(negedge clk);
        a8_rst_n = 1'b1;
        check("rst_oe",     a8_data_oe,  1'b0);
        check("rst_extsel", a8_extsel_n, 1'b1);
        check("rst_mpd",    a8_mpd_n,    1'b1);
        check("rst_irq",    a8_irq_n,    1'b1);
        for (int i = 0; i < 6; i++) begin
            rd(16'hD700 + 16'(i));
            check($sformatf("rst_reg%0d", i), {s_oe, s_data}, {1'b1, 8'h00});
        end

        // Configure: aperture page $06 -> BASE $214365.
        wr(16'hD700, 8'hFF); wr(16'hD701, 8'h65); wr(16'hD702, 8'h43);
        wr(16'hD703, 8'h21); wr(16'hD704, 8'h06); wr(16'hD705, 8'h06);
        rd(16'hD700); check("ctrl_rb", {s_oe, s_data}, {1'b1, 8'hFF});
        rd(16'hD703); check("base_hi", {s_oe, s_data}, {1'b1, 8'h21});
        check("irq_nopend", a8_irq_n, 1'b1);

        rd(16'h0602);
        check("aper_rd0_ext", s_ext, 1'b0);
        check("aper_rd0",     {s_oe, s_data}, {1'b1, 8'h00});
        check("ext_idle", a8_extsel_n, 1'b1);
        wr(16'h0602, 8'h5A);
        check("aper_wr_ext", s_ext, 1'b0);
        rd(16'h0602); check("aper_rd5a", {s_oe, s_data}, {1'b1, 8'h5A});
        rd(16'h0603); check("aper_nbr",  {s_oe, s_data}, {1'b1, 8'h00});
        rd(16'h0702); check("aper_miss", {s_oe, s_ext}, {1'b0, 1'b1});
        rd(16'hD707); check("reg_hole",  {s_oe, s_ext}, {1'b0, 1'b1});

        // START > END: aperture never hits.
        wr(16'hD704, 8'h07); wr(16'hD705, 8'h06);
        rd(16'h0602); check("start_gt_end", {s_oe, s_ext}, {1'b0, 1'b1});

        // Math-pack disable.
        wr(16'hD700, 8'h04);
        rd(16'hD800); check("mpd_on", {s_mpd, s_oe}, {1'b0, 1'b0});
        check("mpd_low_phase", a8_mpd_n, 1'b1);
        wr(16'hD700, 8'h00);
        rd(16'hD800); check("mpd_off", s_mpd, 1'b1);

        // Interrupt flag.
        wr(16'hD700, 8'h02);
        wr(16'hD706, 8'h01);
`ifdef XIO_IRQ_EN
        check("irq_set", a8_irq_n, 1'b0);
        rd(16'hD706); check("irq_rd1", {s_oe, s_data}, {1'b1, 8'h01});
        wr(16'hD706, 8'h00);
        check("irq_clr", a8_irq_n, 1'b1);
`else
        check("irq_tied", a8_irq_n, 1'b1);
        rd(16'hD706); check("irq_rd0", {s_oe, s_data}, {1'b1, 8'h00});
`endif

        // Refresh cycles are ignored entirely.
        bus_cycle(16'hD700, 1'b1, 8'h00, 1'b0, 280);
        check("ref_rd_oe", s_oe, 1'b0);
        bus_cycle(16'hD700, 1'b0, 8'h55, 1'b0, 280);
        rd(16'hD700); check("ref_no_wr", {s_oe, s_data}, {1'b1, 8'h02});

        // Write dropped when phi2 falls before the sample point.
        bus_cycle(16'hD701, 1'b0, 8'hAA, 1'b1, 100);
        rd(16'hD701); check("short_wr", s_data, 8'h65);

        // Reset in the middle of a read releases the bus at once.
        a8_addr = 16'hD700; a8_rw = 1'b1;
        #100; a8_clk = 1'b1; #60; @(negedge clk);
        check("mid_oe_before", a8_data_oe, 1'b1);
        a8_rst_n = 1'b0;
        #1;
        check("mid_oe_after", a8_data_oe, 1'b0);
        #200; a8_clk = 1'b0; #200;
        @(negedge clk); a8_rst_n = 1'b1;
        rd(16'hD700); check("mid_ctrl0", {s_oe, s_data}, {1'b1, 8'h00});
        rd(16'hD701); check("mid_base0", s_data, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
